// File: rtl/gpio_input_conditioner_pkg.sv
// Shared definitions for the GPIO input conditioner: register indices
// and the per-bit edge qualification helper.
package gpio_input_conditioner_pkg;

    typedef enum logic [1:0] {
        GPIO_IN_STATE    = 2'd0,
        GPIO_IN_IRQ_EN   = 2'd1,
        GPIO_IN_EDGE_SEL = 2'd2,
        GPIO_IN_IRQ_PEND = 2'd3
    } reg_sel_e;

    localparam int BUS_W = 32;

    // A level change qualifies as an event when its direction matches the
    // selected edge: falling=0 wants 0->1, falling=1 wants 1->0.
    function automatic logic edge_hit(input logic change, input logic old_level,
                                      input logic falling);
        return change & (falling ? old_level : ~old_level);
    endfunction

endpackage

// File: rtl/gpio_input_conditioner_debounce.sv
// One-bit synchroniser and debouncer. The accepted level only moves after
// the synced input has disagreed with it for DEBOUNCE_CYCLES consecutive
// cycles; change is high in the cycle whose edge updates the level.
module gpio_input_conditioner_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic change
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   synced;
    logic [CNT_W-1:0]       cnt;

    assign synced = sync_p0[SYNC_STAGES-1];
    assign change = (synced != level) && (cnt == CNT_LAST);

    // Metastability chain: shift the raw pin through SYNC_STAGES flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= '0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], pin};
        end
    end

    // Persistence counter; any agreement with the current level restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (synced == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            level <= synced;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/gpio_input_conditioner.sv
// GPIO input conditioner: per-pin debounce, edge-selected interrupt
// pending bits with write-1-to-clear, and the register read mux.
module gpio_input_conditioner
    import gpio_input_conditioner_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pins_in,
    input  logic [1:0]       regSel,
    input  logic             we,
    input  logic [31:0]      di,
    output logic [31:0]      dout,
    output logic [WIDTH-1:0] level,
    output logic             irq
);

    logic [WIDTH-1:0] change;
    logic [WIDTH-1:0] event_hit;
    logic [WIDTH-1:0] irq_en;
    logic [WIDTH-1:0] edge_sel;
    logic [WIDTH-1:0] irq_pend;
    logic [WIDTH-1:0] w1c;
    reg_sel_e         sel;
    logic             unused_di;

    assign sel       = reg_sel_e'(regSel);
    assign unused_di = ^di;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        gpio_input_conditioner_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk   (clk),
            .reset (reset),
            .pin   (pins_in[i]),
            .level (level[i]),
            .change(change[i])
        );
        assign event_hit[i] = edge_hit(change[i], level[i], edge_sel[i]);
    end

    assign w1c = (we && sel == GPIO_IN_IRQ_PEND) ? di[WIDTH-1:0] : '0;

    // Config registers and pending bits; a new event beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en   <= '0;
            edge_sel <= '0;
            irq_pend <= '0;
        end else begin
            if (we && sel == GPIO_IN_IRQ_EN)   irq_en   <= di[WIDTH-1:0];
            if (we && sel == GPIO_IN_EDGE_SEL) edge_sel <= di[WIDTH-1:0];
            irq_pend <= (irq_pend & ~w1c) | event_hit;
        end
    end

    // Side-effect-free read mux, upper bus bits zero.
    always_comb begin
        dout = '0;
        case (sel)
            GPIO_IN_STATE:    dout[WIDTH-1:0] = level;
            GPIO_IN_IRQ_EN:   dout[WIDTH-1:0] = irq_en;
            GPIO_IN_EDGE_SEL: dout[WIDTH-1:0] = edge_sel;
            GPIO_IN_IRQ_PEND: dout[WIDTH-1:0] = irq_pend;
        endcase
    end

    assign irq = |(irq_pend & irq_en);

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Testbench for gpio_input_conditioner: register table, directed corner
// sequences and randomized pin/register traffic against a window model.
module tb_gpio_input_conditioner;

    localparam int W  = 8;
    localparam int SS = 2;
    localparam int DC = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  pins_in;
    logic [1:0]    regSel;
    logic          we;
    logic [31:0]   di;
    logic [31:0]   dout;
    logic [W-1:0]  level;
    logic          irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gpio_input_conditioner #(
        .WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk(clk), .reset(reset), .pins_in(pins_in), .regSel(regSel),
        .we(we), .di(di), .dout(dout), .level(level), .irq(irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a pin level is accepted once the last DC synced samples
    // all oppose the current level and no change happened in those DC cycles.
    logic [W-1:0] hist[$];
    logic [W-1:0] m_level, m_en, m_esel, m_pend;
    int           sc[W];
    bit           m_valid = 1'b0;

    function automatic logic [31:0] m_dout(input logic [1:0] s);
        case (s)
            2'd0:    return 32'(m_level);
            2'd1:    return 32'(m_en);
            2'd2:    return 32'(m_esel);
            default: return 32'(m_pend);
        endcase
    endfunction

    always @(posedge clk) begin
        logic [W-1:0] nxt, ev, clr;
        bit           opp;
        if (reset) begin
            hist.delete();
            for (int k = 0; k < SS + DC; k++) hist.push_back('0);
            m_level = '0; m_en = '0; m_esel = '0; m_pend = '0;
            for (int i = 0; i < W; i++) sc[i] = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            hist.push_back(pins_in);
            if (hist.size() > SS + DC + 1) void'(hist.pop_front());
            nxt = m_level;
            ev  = '0;
            for (int i = 0; i < W; i++) begin
                if (sc[i] < DC) sc[i]++;
                opp = 1'b1;
                for (int k = SS; k < SS + DC; k++)
                    if (hist[hist.size() - 1 - k][i] == m_level[i]) opp = 1'b0;
                if (opp && sc[i] >= DC) begin
                    nxt[i] = ~m_level[i];
                    sc[i]  = 0;
                    if (m_esel[i] ? m_level[i] : !m_level[i]) ev[i] = 1'b1;
                end
            end
            clr    = (we && regSel == 2'd3) ? di[W-1:0] : '0;
            m_pend = (m_pend & ~clr) | ev;
            if (we && regSel == 2'd1) m_en   = di[W-1:0];
            if (we && regSel == 2'd2) m_esel = di[W-1:0];
            m_level = nxt;
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (m_valid) begin
            chk("model_level", 32'(level), 32'(m_level));
            chk("model_irq", 32'(irq), 32'(|(m_pend & m_en)));
            chk("model_dout", dout, m_dout(regSel));
        end
    end

    task automatic wr(input logic [1:0] s, input logic [31:0] d);
        @(negedge clk);
        regSel = s; we = 1'b1; di = d;
        @(negedge clk);
        we = 1'b0; di = '0;
    endtask

    task automatic rdchk(input logic [1:0] s, input logic [31:0] exp, input string name);
        @(negedge clk);
        regSel = s;
        #1;
        chk(name, dout, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic        wen;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{2'd1, 1'b1, 32'hFFFF_FFFF, 32'h0000_00FF};
        tbl[1] = '{2'd2, 1'b1, 32'h1234_5678, 32'h0000_0078};
        tbl[2] = '{2'd0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[3] = '{2'd3, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[4] = '{2'd1, 1'b0, 32'hDEAD_BEEF, 32'h0000_00FF};
        tbl[5] = '{2'd2, 1'b1, 32'h0000_0100, 32'h0000_0000};
        tbl[6] = '{2'd1, 1'b1, 32'h0000_00A5, 32'h0000_00A5};
        tbl[7] = '{2'd1, 1'b1, 32'h0000_0000, 32'h0000_0000};

        // Reset with all pins high.
        pins_in = '1; reset = 1'b1; we = 1'b0; regSel = 2'd0; di = '0;
        cyc(3);
        chk("reset_level", 32'(level), 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        for (int k = 0; k < 4; k++) begin
            regSel = k[1:0];
            #1;
            chk($sformatf("reset_do_%0d", k), dout, 32'h0);
        end

        // Pins held high through reset rise after the full latency.
        @(negedge clk);
        reset = 1'b0; regSel = 2'd0;
        cyc(17);
        chk("thru_reset_early", 32'(level), 32'h00);
        cyc(1);
        chk("thru_reset_rise", 32'(level), 32'hFF);
        rdchk(2'd3, 32'hFF, "thru_reset_pend");
        pins_in = '0;
        cyc(22);
        wr(2'd3, 32'hFF);
        rdchk(2'd3, 32'h00, "pend_cleared");

        // Register access table.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            regSel = tbl[k].sel; we = tbl[k].wen; di = tbl[k].data;
            @(negedge clk);
            we = 1'b0; di = '0;
            #1;
            chk($sformatf("table_%0d", k), dout, tbl[k].exp);
        end

        // Step latency on pin 0.
        @(negedge clk);
        pins_in[0] = 1'b1;
        cyc(17);
        chk("latency_early", 32'(level), 32'h00);
        cyc(1);
        chk("latency_rise", 32'(level), 32'h01);
        rdchk(2'd0, 32'h01, "latency_state");
        pins_in[0] = 1'b0;
        cyc(22);
        wr(2'd3, 32'hFF);

        // Short glitch on pin 3 is rejected.
        @(negedge clk);
        pins_in[3] = 1'b1;
        cyc(10);
        pins_in[3] = 1'b0;
        cyc(30);
        chk("glitch_level", 32'(level), 32'h00);
        rdchk(2'd3, 32'h00, "glitch_pend");

        // Per-bit edge select.
        wr(2'd2, 32'h02);
        wr(2'd1, 32'h03);
        @(negedge clk);
        pins_in[1] = 1'b1;
        cyc(22);
        rdchk(2'd3, 32'h00, "edge_pin1_rise_pend");
        chk("edge_pin1_level", 32'(level), 32'h02);
        @(negedge clk);
        pins_in[0] = 1'b1;
        cyc(17);
        chk("edge_irq_before", 32'(irq), 32'h0);
        cyc(1);
        chk("edge_irq_after", 32'(irq), 32'h1);
        rdchk(2'd3, 32'h01, "edge_pin0_rise_pend");
        @(negedge clk);
        pins_in[1] = 1'b0;
        cyc(22);
        rdchk(2'd3, 32'h03, "edge_pin1_fall_pend");
        wr(2'd3, 32'h03);
        rdchk(2'd3, 32'h00, "edge_clear");
        chk("edge_clear_irq", 32'(irq), 32'h0);

        // Clear racing a new event on pin 0.
        @(negedge clk);
        pins_in[0] = 1'b0;
        cyc(22);
        pins_in[0] = 1'b1;
        cyc(17);
        regSel = 2'd3; we = 1'b1; di = 32'h01;
        @(negedge clk);
        we = 1'b0; di = '0;
        #1;
        chk("race_set_wins", dout, 32'h01);
        wr(2'd3, 32'h01);
        rdchk(2'd3, 32'h00, "race_then_clear");
        chk("race_irq", 32'(irq), 32'h0);

        // Masking and register width.
        wr(2'd1, 32'h0);
        @(negedge clk);
        pins_in[2] = 1'b1;
        cyc(22);
        rdchk(2'd3, 32'h04, "mask_pend");
        chk("mask_irq", 32'(irq), 32'h0);
        wr(2'd1, 32'hFFFF_FFFF);
        rdchk(2'd1, 32'hFF, "mask_en_width");
        chk("mask_irq_on", 32'(irq), 32'h1);
        wr(2'd0, 32'hFF);
        rdchk(2'd0, 32'h05, "state_readonly");

        // Randomized pin and register traffic.
        for (int c = 0; c < 160; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
            pins_in = W'($urandom);
            for (int h = $urandom_range(1, 30); h > 0; h--) begin
                regSel = 2'($urandom_range(0, 3));
                we     = ($urandom_range(0, 3) == 0);
                di     = $urandom;
                if ($urandom_range(0, 7) == 0) pins_in[$urandom_range(0, W-1)] ^= 1'b1;
                @(negedge clk);
            end
            we = 1'b0;
        end

        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
